// File: rtl/hsem_lock_arb_pkg.sv
// Shared definitions for the hardware semaphore lock arbiter:
// op encodings, response codes, FSM states and default sizing.
package hsem_lock_arb_pkg;

  localparam int DEF_NUM_SEM   = 32;
  localparam int DEF_SEM_IDX_W = 5;
  localparam int DEF_PID_W     = 8;

  typedef enum logic [1:0] {
    OP_TAKE    = 2'b00,
    OP_RELEASE = 2'b01,
    OP_QUERY   = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK              = 3'd0,
    ERR_LOCKED_BY_OTHER = 3'd1,
    ERR_NOT_OWNER       = 3'd2,
    ERR_ALREADY_FREE    = 3'd3,
    ERR_BAD_OP          = 3'd4,
    ERR_BAD_ID          = 3'd5,
    ERR_ABORTED         = 3'd6
  } err_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/hsem_rr_arb2.sv
// Two-request round-robin arbiter. When both cores request, the core
// selected by ptr wins; a lone requester always wins.
module hsem_rr_arb2 (
  input  logic req_0,
  input  logic req_1,
  input  logic ptr,
  output logic gnt_0,
  output logic gnt_1
);

  assign gnt_0 = req_0 & (~req_1 | ~ptr);
  assign gnt_1 = req_1 & (~req_0 | ptr);

endmodule

// File: rtl/hsem_lock_arb.sv
// Lock arbiter and ownership table for the hardware semaphore.
// Two cores issue take/release/query requests; a round-robin arbiter picks
// one per IDLE cycle, the following EXEC cycle evaluates it against the
// table and returns a one-cycle response. Free pulses feed the interrupt
// engine. Optional macro HSEM_PROCID_EN adds per-entry PID ownership.
module hsem_lock_arb
  import hsem_lock_arb_pkg::*;
#(
  parameter int NUM_SEM   = DEF_NUM_SEM,
  parameter int SEM_IDX_W = DEF_SEM_IDX_W,
  parameter int PID_W     = DEF_PID_W
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 req_valid_0,
  input  logic                 req_valid_1,
  output logic                 req_ready_0,
  output logic                 req_ready_1,
  input  logic [1:0]           req_op_0,
  input  logic [1:0]           req_op_1,
  input  logic [SEM_IDX_W-1:0] req_id_0,
  input  logic [SEM_IDX_W-1:0] req_id_1,
  input  logic [PID_W-1:0]     req_pid_0,
  input  logic [PID_W-1:0]     req_pid_1,
  output logic                 rsp_valid_0,
  output logic                 rsp_valid_1,
  output logic [2:0]           rsp_err_0,
  output logic [2:0]           rsp_err_1,
  output logic                 rsp_lock_0,
  output logic                 rsp_lock_1,
  input  logic                 clr_all,
  output logic [NUM_SEM-1:0]   lock_stat,
  output logic [NUM_SEM-1:0]   owner_stat,
  output logic [NUM_SEM-1:0]   free_pulse
);

  localparam logic [NUM_SEM-1:0] ONE_HOT0 = {{(NUM_SEM-1){1'b0}}, 1'b1};

  state_e                 state_reg, state_next;
  logic                   rr_ptr_reg, rr_ptr_next;
  logic [1:0]             op_reg;
  logic [SEM_IDX_W-1:0]   id_reg;
  logic                   core_reg;

  logic [NUM_SEM-1:0]     lock_reg, lock_next;
  logic [NUM_SEM-1:0]     owner_reg, owner_next;
  logic [NUM_SEM-1:0]     free_pulse_reg, free_pulse_next;
  logic [NUM_SEM-1:0]     set_mask, clr_mask, sel_mask;

  logic                   gnt_0, gnt_1;
  logic                   arb_en, accept;
  logic                   is_exec, id_ok;
  logic                   cur_lock, cur_owner, owned;
  err_e                   err_code;
  logic                   lock_after;
  logic                   rsp_fire;

  // Arbitration: only offered in IDLE, out of reset, and when no clear-all.
  hsem_rr_arb2 u_arb (
    .req_0 (req_valid_0),
    .req_1 (req_valid_1),
    .ptr   (rr_ptr_reg),
    .gnt_0 (gnt_0),
    .gnt_1 (gnt_1)
  );

  assign arb_en      = hresetn && (state_reg == ST_IDLE) && !clr_all;
  assign req_ready_0 = arb_en & gnt_0;
  assign req_ready_1 = arb_en & gnt_1;
  assign accept      = req_ready_0 | req_ready_1;
  assign is_exec     = (state_reg == ST_EXEC);

  // Latch the winning request on the accepting edge.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      op_reg   <= '0;
      id_reg   <= '0;
      core_reg <= 1'b0;
    end else if (accept) begin
      op_reg   <= req_ready_1 ? req_op_1 : req_op_0;
      id_reg   <= req_ready_1 ? req_id_1 : req_id_0;
      core_reg <= req_ready_1;
    end
  end

  // Selected-entry lookup. A one-hot select avoids out-of-range indexing
  // when NUM_SEM is not a power of two: out-of-range ids select nothing.
  assign sel_mask  = ONE_HOT0 << id_reg;
  assign id_ok     = (32'(id_reg) < 32'(NUM_SEM));
  assign cur_lock  = |(lock_reg & sel_mask);
  assign cur_owner = |(owner_reg & sel_mask);

`ifdef HSEM_PROCID_EN
  logic [PID_W-1:0] pid_reg;
  logic [PID_W-1:0] pid_tab_reg [NUM_SEM];
  logic [PID_W-1:0] cur_pid;

  // Latch the requester PID alongside the rest of the request.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      pid_reg <= '0;
    end else if (accept) begin
      pid_reg <= req_ready_1 ? req_pid_1 : req_pid_0;
    end
  end

  // Fetch the stored PID of the selected entry.
  always_comb begin
    cur_pid = '0;
    for (int i = 0; i < NUM_SEM; i++) begin
      if (sel_mask[i]) cur_pid = pid_tab_reg[i];
    end
  end

  // Store the PID of the new owner whenever an entry is taken.
  always_ff @(posedge hclk) begin
    for (int i = 0; i < NUM_SEM; i++) begin
      if (!hresetn) begin
        pid_tab_reg[i] <= '0;
      end else if (set_mask[i]) begin
        pid_tab_reg[i] <= pid_reg;
      end
    end
  end

  assign owned = (cur_owner == core_reg) && (cur_pid == pid_reg);
`else
  logic unused_pid;
  assign unused_pid = ^{req_pid_0, req_pid_1};
  assign owned      = (cur_owner == core_reg);
`endif

  // EXEC evaluation: response code, post-op lock state and table edits.
  always_comb begin
    err_code   = ERR_OK;
    lock_after = 1'b0;
    set_mask   = '0;
    clr_mask   = '0;
    if (clr_all) begin
      err_code = ERR_ABORTED;
    end else if (op_reg == OP_RSVD) begin
      err_code   = ERR_BAD_OP;
      lock_after = cur_lock;
    end else if (!id_ok) begin
      err_code = ERR_BAD_ID;
    end else begin
      case (op_reg)
        OP_TAKE: begin
          lock_after = 1'b1;
          if (!cur_lock) begin
            set_mask = sel_mask;
          end else if (!owned) begin
            err_code = ERR_LOCKED_BY_OTHER;
          end
        end
        OP_RELEASE: begin
          if (!cur_lock) begin
            err_code = ERR_ALREADY_FREE;
          end else if (owned) begin
            clr_mask = sel_mask;
          end else begin
            err_code   = ERR_NOT_OWNER;
            lock_after = 1'b1;
          end
        end
        default: begin
          lock_after = cur_lock;
        end
      endcase
    end
    if (!is_exec) begin
      set_mask = '0;
      clr_mask = '0;
    end
  end

  // Per-entry next state: clear-all beats any EXEC edit; a clear-all
  // pulses every entry that was locked, a release pulses its own entry.
  for (genvar gi = 0; gi < NUM_SEM; gi++) begin : g_entry
    assign lock_next[gi]       = clr_all ? 1'b0 :
                                 set_mask[gi] ? 1'b1 :
                                 clr_mask[gi] ? 1'b0 : lock_reg[gi];
    assign owner_next[gi]      = set_mask[gi] ? core_reg : owner_reg[gi];
    assign free_pulse_next[gi] = clr_all ? lock_reg[gi] : clr_mask[gi];
  end

  // Table and free-pulse registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      lock_reg       <= '0;
      owner_reg      <= '0;
      free_pulse_reg <= '0;
    end else begin
      lock_reg       <= lock_next;
      owner_reg      <= owner_next;
      free_pulse_reg <= free_pulse_next;
    end
  end

  // FSM next state; pointer moves to the other core only on a completed op.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_EXEC;
      end
      default: begin
        state_next = ST_IDLE;
        if (!clr_all) rr_ptr_next = ~core_reg;
      end
    endcase
  end

  // FSM state and round-robin pointer registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Response strobes are suppressed while reset is asserted.
  assign rsp_fire    = hresetn && is_exec;
  assign rsp_valid_0 = rsp_fire && !core_reg;
  assign rsp_valid_1 = rsp_fire && core_reg;
  assign rsp_err_0   = rsp_valid_0 ? err_code : 3'd0;
  assign rsp_err_1   = rsp_valid_1 ? err_code : 3'd0;
  assign rsp_lock_0  = rsp_valid_0 && lock_after;
  assign rsp_lock_1  = rsp_valid_1 && lock_after;

  assign lock_stat   = lock_reg;
  assign owner_stat  = owner_reg;
  assign free_pulse  = free_pulse_reg;

endmodule
